// File: rtl/dma_c2h_gen_pkg.sv
// Shared types and constants for the C2H AXI-Stream packet generator.
// Holds the tusr layout, the FSM state type and the last-beat keep helper.
package dma_c2h_gen_pkg;

    localparam int DATA_W     = 512;
    localparam int KEEP_W     = 64;
    localparam int USR_W      = 64;
    localparam int USR_LEN_LO = 0;
    localparam int USR_LEN_W  = 16;
    localparam int USR_QID_LO = 16;
    localparam int USR_QID_W  = 11;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // A remainder of zero means the last beat is completely full.
    function automatic logic [KEEP_W-1:0] last_keep(input logic [5:0] rem);
        logic [KEEP_W-1:0] k;
        k = '1;
        if (rem != 6'd0) begin
            k = ~({KEEP_W{1'b1}} << rem);
        end
        return k;
    endfunction

endpackage

// File: rtl/dma_c2h_parity_gen.sv
// Combinational per-byte parity over a 512-bit data word.
// ODD_PARITY inverts every parity bit.
module dma_c2h_parity_gen
    import dma_c2h_gen_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] parity
);

    always_comb begin
        parity = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            parity[i] = (^data[8*i +: 8]) ^ ODD_PARITY;
        end
    end

endmodule

// File: rtl/dma_c2h_axis_pkt_gen.sv
// C2H AXI4-Stream packet source: one command in, one packet of
// incrementing dwords out, with byte parity and tusr sideband.
module dma_c2h_axis_pkt_gen
    import dma_c2h_gen_pkg::*;
#(
    parameter int QID_W      = 11,
    parameter int LEN_W      = 16,
    parameter int MAX_LEN    = 4096,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [QID_W-1:0]  cmd_qid,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_seed,
    output logic [DATA_W-1:0] c2h_tdata,
    output logic [KEEP_W-1:0] c2h_tparity,
    output logic              c2h_tlast,
    output logic              c2h_tvalid,
    output logic [KEEP_W-1:0] c2h_tkeep,
    output logic [USR_W-1:0]  c2h_tusr,
    input  logic              c2h_tready,
    output logic              cmd_err,
    output logic [31:0]       pkt_cnt,
    output logic              busy
);

    localparam int BW = LEN_W - 5;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t state, state_n;

    logic [31:0]       seed_r;
    logic [5:0]        rem_r;
    logic [BW-1:0]     last_r;
    logic [BW-1:0]     bidx;

    logic              len_ok;
    logic              accept;
    logic              reject;
    logic              load;
    logic              done;
    logic [BW-1:0]     beats_cmd;
    logic [BW-1:0]     gen_idx;
    logic [31:0]       gen_seed;
    logic [5:0]        gen_rem;
    logic              gen_last;
    logic [KEEP_W-1:0] gen_keep;
    logic [DATA_W-1:0] gen_data;
    logic [KEEP_W-1:0] gen_par;
    logic [USR_W-1:0]  usr_cmd;

    assign len_ok = (cmd_len != '0) && (cmd_len <= MAX_L);
    assign beats_cmd = BW'(cmd_len >> 6) + BW'(cmd_len[5:0] != 6'd0);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (len_ok) begin
                        accept  = 1'b1;
                        load    = 1'b1;
                        state_n = STREAM;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (c2h_tvalid && c2h_tready) begin
                    if (c2h_tlast) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // In IDLE the first beat is built straight from the command inputs.
    always_comb begin
        gen_seed = (state == IDLE) ? cmd_seed : seed_r;
        gen_idx  = (state == IDLE) ? '0 : bidx;
        gen_rem  = (state == IDLE) ? cmd_len[5:0] : rem_r;
        gen_last = (state == IDLE) ? (beats_cmd == BW'(1)) : (bidx == last_r);
        gen_keep = gen_last ? last_keep(gen_rem) : '1;
        gen_data = '0;
        for (int j = 0; j < DATA_W / 32; j++) begin
            gen_data[32*j +: 32] = gen_seed + 32'({gen_idx, 4'h0}) + 32'(j);
        end
        for (int i = 0; i < KEEP_W; i++) begin
            if (!gen_keep[i]) begin
                gen_data[8*i +: 8] = 8'h00;
            end
        end
        usr_cmd = '0;
        usr_cmd[USR_LEN_LO +: LEN_W] = cmd_len;
        usr_cmd[USR_QID_LO +: QID_W] = cmd_qid;
    end

    dma_c2h_parity_gen #(
        .ODD_PARITY (ODD_PARITY)
    ) u_par (
        .data   (gen_data),
        .parity (gen_par)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            pkt_cnt     <= '0;
            seed_r      <= '0;
            rem_r       <= '0;
            last_r      <= '0;
            bidx        <= '0;
            c2h_tvalid  <= 1'b0;
            c2h_tlast   <= 1'b0;
            c2h_tdata   <= '0;
            c2h_tparity <= {KEEP_W{ODD_PARITY}};
            c2h_tkeep   <= '0;
            c2h_tusr    <= '0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n == STREAM);
            cmd_err   <= reject;
            if (accept) begin
                seed_r   <= cmd_seed;
                rem_r    <= cmd_len[5:0];
                last_r   <= beats_cmd - BW'(1);
                c2h_tusr <= usr_cmd;
            end
            if (load) begin
                c2h_tvalid  <= 1'b1;
                c2h_tlast   <= gen_last;
                c2h_tdata   <= gen_data;
                c2h_tparity <= gen_par;
                c2h_tkeep   <= gen_keep;
                bidx        <= gen_idx + BW'(1);
            end
            if (done) begin
                c2h_tvalid <= 1'b0;
                c2h_tlast  <= 1'b0;
                pkt_cnt    <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dma_c2h_axis_pkt_gen.sv
// Scoreboard bench for dma_c2h_axis_pkt_gen: commands push expected
// beats, a negedge monitor pops and compares on every handshake.
module tb_dma_c2h_axis_pkt_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [10:0]  cmd_qid;
    logic [15:0]  cmd_len;
    logic [31:0]  cmd_seed;
    logic [511:0] tdata;
    logic [63:0]  tparity;
    logic         tlast;
    logic         tvalid;
    logic [63:0]  tkeep;
    logic [63:0]  tusr;
    logic         tready;
    logic         cmd_err;
    logic [31:0]  pkt_cnt;
    logic         busy;

    logic         o_cmd_valid;
    logic         o_cmd_ready;
    logic [10:0]  o_cmd_qid;
    logic [15:0]  o_cmd_len;
    logic [31:0]  o_cmd_seed;
    logic [511:0] o_tdata;
    logic [63:0]  o_tparity;
    logic         o_tlast;
    logic         o_tvalid;
    logic [63:0]  o_tkeep;
    logic [63:0]  o_tusr;
    logic         o_tready;
    logic         o_cmd_err;
    logic [31:0]  o_pkt_cnt;
    logic         o_busy;

    assign o_tready = 1'b1;

    dma_c2h_axis_pkt_gen #(
        .QID_W(11), .LEN_W(16), .MAX_LEN(4096), .ODD_PARITY(1'b0)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_qid(cmd_qid), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .c2h_tdata(tdata), .c2h_tparity(tparity), .c2h_tlast(tlast),
        .c2h_tvalid(tvalid), .c2h_tkeep(tkeep), .c2h_tusr(tusr),
        .c2h_tready(tready), .cmd_err(cmd_err), .pkt_cnt(pkt_cnt),
        .busy(busy)
    );

    dma_c2h_axis_pkt_gen #(
        .QID_W(11), .LEN_W(16), .MAX_LEN(4096), .ODD_PARITY(1'b1)
    ) dut_odd (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .cmd_valid(o_cmd_valid), .cmd_ready(o_cmd_ready),
        .cmd_qid(o_cmd_qid), .cmd_len(o_cmd_len), .cmd_seed(o_cmd_seed),
        .c2h_tdata(o_tdata), .c2h_tparity(o_tparity), .c2h_tlast(o_tlast),
        .c2h_tvalid(o_tvalid), .c2h_tkeep(o_tkeep), .c2h_tusr(o_tusr),
        .c2h_tready(o_tready), .cmd_err(o_cmd_err), .pkt_cnt(o_pkt_cnt),
        .busy(o_busy)
    );

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic [63:0]  u;
        logic [63:0]  p;
    } beat_t;

    beat_t        sb[$];
    beat_t        mon_e;
    int           checks = 0;
    int           passes = 0;
    logic [511:0] lst_d;
    logic [63:0]  lst_k;
    logic [63:0]  lst_u;
    bit           stall_mode = 1'b0;
    int           ph = 0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [511:0] exp_data(input logic [31:0] s,
                                              input int b,
                                              input logic [63:0] k);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[32*j +: 32] = s + 32'(16 * b + j);
        for (int i = 0; i < 64; i++) if (!k[i]) d[8*i +: 8] = 8'h00;
        return d;
    endfunction

    function automatic logic [63:0] exp_par(input logic [511:0] d,
                                            input logic odd);
        logic [63:0] p;
        for (int i = 0; i < 64; i++) begin
            p[i] = d[8*i] ^ d[8*i+1] ^ d[8*i+2] ^ d[8*i+3] ^
                   d[8*i+4] ^ d[8*i+5] ^ d[8*i+6] ^ d[8*i+7] ^ odd;
        end
        return p;
    endfunction

    task automatic push_pkt(input logic [10:0] q, input logic [15:0] l,
                            input logic [31:0] s);
        int nb;
        int r;
        beat_t e;
        nb = (int'(l) + 63) / 64;
        r  = int'(l) % 64;
        for (int b = 0; b < nb; b++) begin
            e.l = (b == nb - 1);
            e.k = (e.l && r != 0) ? ((64'd1 << r) - 64'd1) : {64{1'b1}};
            e.d = exp_data(s, b, e.k);
            e.u = 64'(l) | (64'(q) << 16);
            e.p = exp_par(e.d, 1'b0);
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [10:0] q, input logic [15:0] l,
                        input logic [31:0] s);
        int n;
        n = 0;
        if (l != 16'd0 && l <= 16'd4096) push_pkt(q, l, s);
        cmd_qid   = q;
        cmd_len   = l;
        cmd_seed  = s;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) chk("cmd_timeout", 512'(cmd_ready), 512'(1'b1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk("done_timeout", 512'(sb.size()), 512'(0));
    endtask

    // tready: constant 1, or a repeating 1-0-0-1 pattern when stalling
    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            tready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end else begin
            tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && tvalid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_beat", 512'(tvalid), 512'(1'b0));
            end else if (tready === 1'b1) begin
                mon_e = sb.pop_front();
                chk("beat_data", tdata, mon_e.d);
                chk("beat_keep", 512'(tkeep), 512'(mon_e.k));
                chk("beat_last", 512'(tlast), 512'(mon_e.l));
                chk("beat_usr", 512'(tusr), 512'(mon_e.u));
                chk("beat_par", 512'(tparity), 512'(mon_e.p));
                lst_d = tdata;
                lst_k = tkeep;
                lst_u = tusr;
            end else begin
                chk("stall_data", tdata, sb[0].d);
                chk("stall_last", 512'(tlast), 512'(sb[0].l));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_qid     = '0;
        cmd_len     = '0;
        cmd_seed    = '0;
        o_cmd_valid = 1'b0;
        o_cmd_qid   = '0;
        o_cmd_len   = '0;
        o_cmd_seed  = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 512'(tvalid), 512'(1'b0));
        chk("rst_tlast", 512'(tlast), 512'(1'b0));
        chk("rst_tdata", tdata, 512'd0);
        chk("rst_tpar", 512'(tparity), 512'd0);
        chk("rst_tkeep", 512'(tkeep), 512'd0);
        chk("rst_tusr", 512'(tusr), 512'd0);
        chk("rst_err", 512'(cmd_err), 512'(1'b0));
        chk("rst_cnt", 512'(pkt_cnt), 512'd0);
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_odd_par", 512'(o_tparity), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 512'(cmd_ready), 512'(1'b1));

        send(11'd5, 16'd64, 32'h1000);
        wait_done();
        chk("p1_usr", 512'(lst_u), 512'(64'h0005_0040));
        chk("p1_dw0", 512'(lst_d[31:0]), 512'(32'h1000));
        chk("p1_dw15", 512'(lst_d[511:480]), 512'(32'h100F));
        chk("p1_cnt", 512'(pkt_cnt), 512'd1);

        send(11'd1, 16'd130, 32'h0);
        wait_done();
        chk("p2_keep", 512'(lst_k), 512'(64'h3));
        chk("p2_last_data", lst_d, 512'h20);
        chk("p2_cnt", 512'(pkt_cnt), 512'd2);

        stall_mode = 1'b1;
        send(11'h7FF, 16'd200, 32'hABCD_0000);
        wait_done();
        stall_mode = 1'b0;
        chk("p3_keep", 512'(lst_k), 512'(64'hFF));
        chk("p3_cnt", 512'(pkt_cnt), 512'd3);

        send(11'd0, 16'd0, 32'h0);
        chk("err0_pulse", 512'(cmd_err), 512'(1'b1));
        chk("err0_tvalid", 512'(tvalid), 512'(1'b0));
        @(posedge clk); #1;
        chk("err0_clear", 512'(cmd_err), 512'(1'b0));
        chk("err0_ready", 512'(cmd_ready), 512'(1'b1));
        send(11'd0, 16'd4097, 32'h0);
        chk("err1_pulse", 512'(cmd_err), 512'(1'b1));
        chk("err1_busy", 512'(busy), 512'(1'b0));
        @(posedge clk); #1;
        chk("err1_clear", 512'(cmd_err), 512'(1'b0));
        chk("err_cnt", 512'(pkt_cnt), 512'd3);

        send(11'd1, 16'd1, 32'h7);
        send(11'd2, 16'd65, 32'h10);
        wait_done();
        chk("b2b_keep", 512'(lst_k), 512'(64'h1));
        chk("b2b_data", lst_d, 512'h20);
        chk("b2b_cnt", 512'(pkt_cnt), 512'd5);

        send(11'd9, 16'd4096, 32'hFFFF_FFF0);
        wait_done();
        chk("max_dw15", 512'(lst_d[511:480]), 512'(32'h3EF));
        chk("max_usr", 512'(lst_u), 512'(64'h0009_1000));
        chk("max_cnt", 512'(pkt_cnt), 512'd6);

        o_cmd_qid   = 11'd1;
        o_cmd_len   = 16'd4;
        o_cmd_seed  = 32'hFFFF_FFFF;
        o_cmd_valid = 1'b1;
        @(posedge clk); #1;
        o_cmd_valid = 1'b0;
        chk("odd_tvalid", 512'(o_tvalid), 512'(1'b1));
        chk("odd_dw0", 512'(o_tdata[31:0]), 512'(32'hFFFF_FFFF));
        chk("odd_hi_zero", 512'(o_tdata[511:32]), 512'd0);
        chk("odd_par", 512'(o_tparity), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("odd_keep", 512'(o_tkeep), 512'(64'hF));
        chk("odd_last", 512'(o_tlast), 512'(1'b1));
        @(posedge clk); #1;
        chk("odd_done", 512'(o_tvalid), 512'(1'b0));
        chk("odd_cnt", 512'(o_pkt_cnt), 512'd1);

        send(11'd3, 16'd256, 32'h55);
        @(posedge clk); #1;
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 512'(tvalid), 512'(1'b0));
        chk("mid_rst_cnt", 512'(pkt_cnt), 512'd0);
        chk("mid_rst_busy", 512'(busy), 512'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 512'(cmd_ready), 512'(1'b1));
        chk("post_rst_tvalid", 512'(tvalid), 512'(1'b0));
        send(11'd4, 16'd64, 32'h2000);
        wait_done();
        chk("post_rst_cnt", 512'(pkt_cnt), 512'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
